// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer and its event FIFO.
// Event record layout is {code, press}: press in bit 0, key code above it.
package key_pkg;

  // Sample period for 20 ms at a 50 MHz clock.
  localparam int CLK_DIV_20MS_50M = 1_000_000;

  // Bit positions inside a packed event record {code, press}.
  localparam int EVT_PRESS_LSB = 0;
  localparam int EVT_CODE_LSB  = 1;

  // Width of a key code for nkeys key lines.
  function automatic int cw(input int nkeys);
    return (nkeys < 2) ? 1 : $clog2(nkeys);
  endfunction

  // Width of a packed event record.
  function automatic int evt_w(input int nkeys);
    return cw(nkeys) + 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through synchronous FIFO for debounced key events.
// dout always shows the head entry; it changes only on a pop or on a
// push into an empty FIFO. Push and pop together are accepted when full.
// Optional macro KEY_DEBOUNCE_IRQ_EN adds the empty_next output used by
// the interrupt logic of the top level.
module key_evt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef KEY_DEBOUNCE_IRQ_EN
  output logic             empty_next,
`endif
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    level_nx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == {LW{1'b0}});
  assign full    = (level == LVL_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_nx = level;
    case ({do_push, do_pop})
      2'b10:   level_nx = level + LW'(1);
      2'b01:   level_nx = level - LW'(1);
      default: level_nx = level;
    endcase
  end

`ifdef KEY_DEBOUNCE_IRQ_EN
  assign empty_next = (level_nx == {LW{1'b0}});
`endif

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      level  <= {LW{1'b0}};
    end else begin
      level <= level_nx;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {WIDTH{1'b0}};
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/key_debounce_evt.sv
// Keypad debouncer with per-key stability filter and a queued
// {key code, direction} event stream behind a valid/ready handshake.
// Optional macro KEY_DEBOUNCE_IRQ_EN adds a registered irq output that
// follows (event available OR overflow) one cycle after the condition.
module key_debounce_evt
  import key_pkg::*;
#(
  parameter int NKEYS      = 16,
  parameter int CLK_DIV    = CLK_DIV_20MS_50M,
  parameter int STABLE_N   = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
`ifdef KEY_DEBOUNCE_IRQ_EN
  output logic                 irq,
`endif
  input  logic [NKEYS-1:0]     key_in,
  output logic [NKEYS-1:0]     key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [cw(NKEYS)-1:0] evt_code,
  output logic                 evt_press,
  output logic                 evt_ovf,
  input  logic                 ovf_clr
);

  localparam int CW = cw(NKEYS);
  localparam int EW = evt_w(NKEYS);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0]    DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [3:0]       CNT_MAX  = 4'(STABLE_N - 1);
  localparam logic [NKEYS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {NKEYS{1'b1}} : {NKEYS{1'b0}};

  logic [NKEYS-1:0]      sync1;
  logic [NKEYS-1:0]      sync2;
  logic [NKEYS-1:0]      raw_p;
  logic [DW-1:0]         div;
  logic                  tick;
  logic [NKEYS-1:0][3:0] cnt;
  logic [NKEYS-1:0][3:0] cnt_next;
  logic [NKEYS-1:0]      flip;
  logic [NKEYS-1:0]      pending;
  logic [NKEYS-1:0]      pending_next;
  logic [NKEYS-1:0]      pend_clr;
  logic [CW-1:0]         sel_idx;
  logic                  sel_vld;
  logic                  push;
  logic [EW-1:0]         push_data;
  logic                  ovf_set;
  logic                  ovf_next;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         fifo_dout;
`ifdef KEY_DEBOUNCE_IRQ_EN
  logic                  fifo_empty_next;
`endif

  // Two-flop synchroniser, idling at the released level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= INACTIVE;
      sync2 <= INACTIVE;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // Normalise so that 1 always means pressed.
  assign raw_p = sync2 ^ INACTIVE;

  // Sample-period divider; tick marks its last count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div <= {DW{1'b0}};
    end else if (tick) begin
      div <= {DW{1'b0}};
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick = (div == DIV_MAX);

  // Per-key stability counters: flip after STABLE_N differing ticks in a row.
  always_comb begin
    flip     = {NKEYS{1'b0}};
    cnt_next = cnt;
    for (int i = 0; i < NKEYS; i++) begin
      if (!tick) begin
        cnt_next[i] = cnt[i];
      end else if (raw_p[i] == key_state[i]) begin
        cnt_next[i] = 4'd0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt_next[i] = 4'd0;
        flip[i]     = 1'b1;
      end else begin
        cnt_next[i] = cnt[i] + 4'd1;
      end
    end
  end

  // Scanner: lowest pending key goes to the FIFO when there is room.
  always_comb begin
    sel_idx = {CW{1'b0}};
    sel_vld = 1'b0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      sel_idx = pending[i] ? CW'(i) : sel_idx;
      sel_vld = sel_vld | pending[i];
    end
    push              = sel_vld & ~fifo_full;
    push_data         = {sel_idx, key_state[sel_idx]};
    pend_clr          = {NKEYS{1'b0}};
    pend_clr[sel_idx] = push;
    // A fresh flip beats the scanner's clear on the same key.
    pending_next      = (pending & ~pend_clr) | flip;
    // Flipping a key whose previous event is still unqueued loses that event.
    ovf_set           = |(flip & pending & ~pend_clr);
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = evt_ovf;
    end
  end

  // Filter, pending and overflow state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= {(NKEYS * 4){1'b0}};
      key_state <= {NKEYS{1'b0}};
      pending   <= {NKEYS{1'b0}};
      evt_ovf   <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      key_state <= key_state ^ flip;
      pending   <= pending_next;
      evt_ovf   <= ovf_next;
    end
  end

  key_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
`ifdef KEY_DEBOUNCE_IRQ_EN
    .empty_next (fifo_empty_next),
`endif
    .push       (push),
    .din        (push_data),
    .pop        (evt_ready),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_dout[EW-1:EVT_CODE_LSB];
  assign evt_press = fifo_dout[EVT_PRESS_LSB];

`ifdef KEY_DEBOUNCE_IRQ_EN
  // Interrupt request: event available or overflow, one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else begin
      irq <= ~fifo_empty_next | ovf_next;
    end
  end
`endif

endmodule

// File: doc/key_debounce_evt.md
Name: key_debounce_evt

Overview:
- Parametrised successor to the keypad debouncer: filters NKEYS raw key lines with a configurable sample period and stability count.
- Publishes the debounced level of every key.
- Each press or release becomes a {key code, direction} event, queued in a small FIFO with a valid/ready handshake.
- Sits between the keypad pins and the AHB/APB keyboard peripheral, replacing the single-cycle "en" change pulse.

Parameters:
- NKEYS, 16, number of key lines (2..32).
- CLK_DIV, 1_000_000, clk cycles per sample tick (20 ms at 50 MHz); >=2.
- STABLE_N, 3, consecutive differing samples required to flip a key's state (1..15).
- ACTIVE_LOW, 1, 1: key_in low = pressed; 0: high = pressed.
- FIFO_DEPTH, 4, event FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- key_in  in  NKEYS  raw asynchronous key lines
- key_state  out  NKEYS  debounced level, 1 = pressed
- evt_valid  out  1  FIFO head event available
- evt_ready  in  1  consumer accepts head this cycle
- evt_code  out  CW=$clog2(NKEYS)  key index of head event
- evt_press  out  1  1 = press, 0 = release
- evt_ovf  out  1  sticky: event coalesced or lost
- ovf_clr  in  1  clears evt_ovf

Behaviour:
- Reset:
  - All flops reset asynchronously on rstn low.
  - Synchroniser flops reset to the inactive level: all 1s if ACTIVE_LOW, else all 0s.
  - key_state=0, counters=0, pending=0, FIFO empty, evt_valid=0, evt_code=0, evt_press=0, evt_ovf=0.
  - Reset mid-operation discards all queued and pending events.
- Input path:
  - key_in passes through a 2-flop synchroniser.
  - raw_p[i] = sync[i] XOR ACTIVE_LOW, so raw_p is 1 when the key is pressed.
- Tick:
  - divider counts 0..CLK_DIV-1 and wraps to 0.
  - tick is 1 for one cycle when divider == CLK_DIV-1.
- Per-key filter, evaluated only on tick:
  - If raw_p[i] == key_state[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_N-1: key_state[i] toggles, cnt[i] <= 0, pending[i] <= 1.
  - Else: cnt[i] increments.
  - Any agreeing sample restarts the count.
  - key_state updates in the cycle after the STABLE_N-th consecutive differing tick.
- Event scanner, every cycle:
  - Selects the lowest index i with pending[i]=1.
  - If the FIFO is not full, pushes {i, key_state[i]} and clears pending[i].
  - At most one push per cycle; a simultaneous set from the filter wins over the clear, so pending stays 1.
  - A key that flips again while still pending stays pending and is pushed with its current state. The intermediate event is lost and evt_ovf is set.
- FIFO:
  - First-word-fall-through.
  - evt_valid = not empty; evt_code and evt_press show the head entry.
  - Pop when evt_valid && evt_ready.
  - Push and pop in the same cycle are both legal when full, and occupancy is unchanged.
  - evt_ready with an empty FIFO is ignored.
  - Output changes only on pop or on a push into an empty FIFO.
- Latency: from the key_state change, the push happens the next cycle (if not full), and evt_valid asserts the cycle after the push.
- evt_ovf:
  - Set on coalescing (pending hit while pending).
  - ovf_clr clears it next cycle; a set in the same cycle wins over the clear.

Optional Feature:
- Macro: KEY_DEBOUNCE_IRQ_EN.
- Defined: adds output irq (1 bit), registered, reset 0. irq = evt_valid_next OR evt_ovf_next, asserting one cycle after the condition.
- Undefined: no irq port and no irq logic; the module is otherwise identical.

Decomposition:
- Shared package/header key_pkg holds:
  - the event record layout {code, press};
  - the width helper CW;
  - default CLK_DIV_20MS_50M = 1_000_000.
- One natural sub-module: key_evt_fifo, a parametrised FWFT sync FIFO (WIDTH=CW+1, DEPTH=FIFO_DEPTH, full/empty flags).
- Divider, filters and scanner stay in the top level.

Test Plan:
Simulation setup: CLK_DIV=4, STABLE_N=3, NKEYS=16, ACTIVE_LOW=1, FIFO_DEPTH=4.
- key_in[5] driven low and held -> key_state[5]=1 after 3 ticks; one event {code=5, press=1} with evt_ready=1. Release -> {5, 0}.
- key_in[2] glitches low for 2 ticks, then high -> key_state stays 0, no event, cnt[2] returns to 0.
- Keys 3 and 9 pressed on the same tick -> events delivered in order {3,1} then {9,1} on consecutive cycles.
- evt_ready=0, 5 distinct presses -> FIFO holds 4 and 1 remains pending. Then evt_ready=1 -> all 5 delivered in index order and evt_ovf stays 0.
- evt_ready=0 with FIFO full, key 7 press then release while pending -> one {7,0} event and evt_ovf=1. ovf_clr pulse -> evt_ovf=0.
- Assert rstn low with 3 events queued and 1 pending -> evt_valid=0 and key_state=0 immediately. No stale events after release of reset.
